// File: rtl/rv32_pkg.sv
// Shared RV32 writeback definitions: result-source encodings, load funct3
// codes and the stage-register payload.
package rv32_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_CSR  = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]      rd_addr;
        logic            wr_en;
        wb_sel_e         wb_sel;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] load_data;
        logic [2:0]      load_size;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] csr_data;
    } wb_req_t;
endpackage

// File: rtl/rv32_writeback_stage_if.sv
// MEM->WB bundle plus the register-file write port; master is the MEM side.
interface rv32_writeback_stage_if;
    logic        valid_in;
    logic        stall_in;
    logic        flush_in;
    logic [4:0]  rd_addr_in;
    logic        wr_en_in;
    logic [1:0]  wb_sel_in;
    logic [31:0] alu_result_in;
    logic [31:0] load_data_in;
    logic [2:0]  load_size_in;
    logic [31:0] pc_plus4_in;
    logic [31:0] csr_data_in;

    logic [4:0]  rd_addr_out;
    logic        wr_en_out;
    logic [31:0] rd_out;
    logic        retire_out;
    logic        load_fault_out;
    logic [63:0] instret_out;

    modport master (
        output valid_in, stall_in, flush_in, rd_addr_in, wr_en_in, wb_sel_in,
               alu_result_in, load_data_in, load_size_in, pc_plus4_in, csr_data_in,
        input  rd_addr_out, wr_en_out, rd_out, retire_out, load_fault_out, instret_out
    );

    modport slave (
        input  valid_in, stall_in, flush_in, rd_addr_in, wr_en_in, wb_sel_in,
               alu_result_in, load_data_in, load_size_in, pc_plus4_in, csr_data_in,
        output rd_addr_out, wr_en_out, rd_out, retire_out, load_fault_out, instret_out
    );
endinterface

// File: rtl/rv32_load_align.sv
// Combinational load extraction: picks byte/halfword at the offset, extends,
// and flags misaligned or reserved-size loads.
module rv32_load_align
    import rv32_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    output logic [31:0] value_o,
    output logic        fault_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // offset[0] is a fault for halfwords, so only offset[1] picks the half
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

        value_o = '0;
        fault_o = 1'b0;
        case (size_i)
            F3_LB:   value_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  value_o = {24'd0, byte_sel};
            F3_LH: begin
                value_o = {{16{half_sel[15]}}, half_sel};
                fault_o = offset_i[0];
            end
            F3_LHU: begin
                value_o = {16'd0, half_sel};
                fault_o = offset_i[0];
            end
            F3_LW: begin
                value_o = word_i;
                fault_o = |offset_i;
            end
            default: fault_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/rv32_writeback_stage.sv
// RV32 writeback stage: one register slot, result select, and a committed
// flag so a stalled instruction writes/retires/faults exactly once.
module rv32_writeback_stage
    import rv32_pkg::*;
(
    input  logic                   riscv32_mp_clk_in,
    input  logic                   riscv32_mp_rst_in,
    rv32_writeback_stage_if.slave  wb
);
    wb_req_t     req_d, req_q;
    logic        valid_d, valid_q;
    logic        committed_d, committed_q;
    logic [63:0] instret_d, instret_q;

    logic [31:0] load_value;
    logic        load_fault_raw;
    logic        first_cycle, fault, retire;

    always_comb begin
        req_d       = req_q;
        valid_d     = valid_q;
        committed_d = committed_q;
        if (!wb.stall_in) begin
            req_d.rd_addr    = wb.rd_addr_in;
            req_d.wr_en      = wb.wr_en_in;
            req_d.wb_sel     = wb_sel_e'(wb.wb_sel_in);
            req_d.alu_result = wb.alu_result_in;
            req_d.load_data  = wb.load_data_in;
            req_d.load_size  = wb.load_size_in;
            req_d.pc_plus4   = wb.pc_plus4_in;
            req_d.csr_data   = wb.csr_data_in;
            valid_d          = wb.valid_in;
            committed_d      = 1'b0;
        end else begin
            committed_d = committed_q | valid_q;
        end
        // flush wins over stall
        if (wb.flush_in) valid_d = 1'b0;
    end

    always_ff @(posedge riscv32_mp_clk_in or posedge riscv32_mp_rst_in) begin
        if (riscv32_mp_rst_in) begin
            req_q       <= '0;
            valid_q     <= 1'b0;
            committed_q <= 1'b0;
            instret_q   <= '0;
        end else begin
            req_q       <= req_d;
            valid_q     <= valid_d;
            committed_q <= committed_d;
            instret_q   <= instret_d;
        end
    end

    rv32_load_align u_align (
        .word_i   (req_q.load_data),
        .offset_i (req_q.alu_result[1:0]),
        .size_i   (req_q.load_size),
        .value_o  (load_value),
        .fault_o  (load_fault_raw)
    );

    always_comb begin
        first_cycle = valid_q & ~committed_q;
        fault       = (req_q.wb_sel == WB_LOAD) & load_fault_raw;
        retire      = first_cycle & ~fault;
        instret_d   = instret_q + 64'(retire);

        case (req_q.wb_sel)
            WB_LOAD: wb.rd_out = load_value;
            WB_PC4:  wb.rd_out = req_q.pc_plus4;
            WB_CSR:  wb.rd_out = req_q.csr_data;
            default: wb.rd_out = req_q.alu_result;
        endcase

        wb.rd_addr_out    = req_q.rd_addr;
        wb.wr_en_out      = retire & req_q.wr_en & (req_q.rd_addr != 5'd0);
        wb.retire_out     = retire;
        wb.load_fault_out = first_cycle & fault;
        wb.instret_out    = instret_q;
    end
endmodule
